// File: rtl/oversample_window_collector.sv
// Collects SAMPLES*OSF oversampled comparator bits into one window, bit k = k-th capture.
// Latency: window/out_valid update 1 clk after the capture that completes a frame.
// Backpressure: 1-deep output register; a frame completing while it is still held is dropped and flagged in overrun.
module oversample_window_collector #(
    parameter int SAMPLES = 2,
    parameter int OSF     = 8,
    localparam int N      = SAMPLES * OSF,
    localparam int CW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          din,
    input  logic          sync,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [N-1:0]  window,
    output logic          overrun,
    output logic [CW-1:0] fill
);

    logic [CW-1:0] cnt;
    logic [N-1:0]  shift;
    logic          complete;
    logic          xfer;
    logic [N-1:0]  frame;

    // A frame completes on its last capture unless a realign overrides it.
    assign complete = en && !sync && (cnt == CW'(N - 1));
    assign xfer     = out_valid && out_ready;
    // The final bit goes straight into the frame; it never lands in shift.
    assign frame    = {din, shift[N-2:0]};
    assign fill     = cnt;

    // Capture path, realign handling and the 1-deep output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            shift     <= '0;
            window    <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (sync) begin
                // Discard the partial frame; a simultaneous capture starts the new one.
                shift   <= '0;
                overrun <= 1'b0;
                if (en) begin
                    shift[0] <= din;
                    cnt      <= CW'(1);
                end else begin
                    cnt <= '0;
                end
            end else if (en) begin
                if (complete) begin
                    cnt   <= '0;
                    shift <= '0;
                end else begin
                    shift[cnt] <= din;
                    cnt        <= cnt + CW'(1);
                end
            end

            if (complete) begin
                if (!out_valid || out_ready) begin
                    window    <= frame;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
